operand_bank_pingpong: RTL and testbench
========================================

Name: operand_bank_pingpong

Overview:
Parametrised, double-buffered operand register bank for the systolic array input path. It assembles a BANK_DEPTH-word operand vector from narrower BEAT_LANES-word input beats, using a valid/ready handshake and an internal beat counter. Two banks run in ping-pong: one fills while the other is presented to the array until the consumer releases it. This lets loading overlap with compute.

Parameters:
DATA_WIDTH, 8, bits per word (lane).
BANK_DEPTH, 8, words per bank; must be an integer multiple of BEAT_LANES.
BEAT_LANES, 4, words delivered per input beat; BEATS = BANK_DEPTH/BEAT_LANES, which must be ≥1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush of pointers, counter and full flags.
in_valid  input  1  input beat valid.
in_ready  output  1  bank accepts a beat this cycle.
in_data  input  BEAT_LANES*DATA_WIDTH  beat; lane i is in_data[i*DATA_WIDTH +: DATA_WIDTH].
out_valid  output  1  presented bank is complete.
out_ready  input  1  consumer releases the presented bank.
out_data  output  BANK_DEPTH*DATA_WIDTH  presented bank; word j is out_data[j*DATA_WIDTH +: DATA_WIDTH].
banks_full  output  2  number of full banks, range 0..2.

Behaviour:
- State:
  - bank0 and bank1 data registers.
  - full[1:0] flags.
  - wr_sel: bank being filled.
  - rd_sel: bank being presented.
  - beat_cnt: range 0..BEATS-1, width max(1, clog2(BEATS)).
- Reset (async): all data registers = 0, full = 0, wr_sel = rd_sel = 0, beat_cnt = 0.
  - Resulting outputs: in_ready = 1, out_valid = 0, out_data = 0, banks_full = 0.
- in_ready = !full[wr_sel]. It depends only on registered state; there is no combinational path from out_ready to in_ready.
- Accept when in_valid && in_ready:
  - Lane i of the beat is written to word beat_cnt*BEAT_LANES + i of bank[wr_sel].
  - If beat_cnt == BEATS-1: set full[wr_sel], toggle wr_sel, clear beat_cnt. Otherwise beat_cnt increments.
- in_valid while in_ready = 0: the beat is not accepted; the source must hold it (stall, no error).
- out_valid = full[rd_sel]; out_data = bank[rd_sel]. Both are a mux of registered state, so there is zero combinational latency from the flag.
- Release when out_valid && out_ready: clear full[rd_sel], toggle rd_sel. Bank data is retained, not zeroed.
- out_ready while out_valid = 0 is ignored.
- Latency:
  - out_valid rises on the edge that accepts the last beat, i.e. it is visible the cycle after that beat.
  - A released bank raises in_ready the cycle after release, if it is the bank being filled.
- Simultaneous completion of a fill and a release: both apply in the same cycle. They always target different banks, because a full bank is never written.
- banks_full = full[0] + full[1], combinational from the flags.
- BEATS == 1: every accepted beat completes a bank.
- clear (sync): takes priority over accept and release in the same cycle.
  - Resets full, wr_sel, rd_sel and beat_cnt to 0.
  - Bank data is retained.
  - A partially filled bank is discarded.
- Reset asserted mid-fill or mid-presentation: immediate return to reset state, with no wait for the clock.
- Throughput: one beat per cycle sustained as long as the consumer releases each bank within BEATS cycles of its completion.

Test Plan:
1. Reset with defaults -> in_ready=1, out_valid=0, banks_full=0, out_data=64'h0.
2. Beats 32'h03020100 then 32'h07060504 on consecutive cycles, out_ready=0 -> out_valid=1 the cycle after the 2nd accept; out_data=64'h0706050403020100; banks_full=1; in_ready stays 1.
3. Four beats with out_ready=0 -> in_ready=0 after the 4th accept, banks_full=2; a held 5th beat 32'hDEADBEEF is not accepted and bank contents are unchanged.
4. From case 3, pulse out_ready for one cycle -> out_data switches to the second bank next cycle, out_valid stays 1, banks_full=1, in_ready=1; the held beat is then accepted into bank0 words 0..3.
5. One beat 32'hAAAAAAAA accepted, then clear, then beats 32'h11111111 and 32'h22222222 -> out_data=64'h2222222211111111; no trace of the discarded beat in words 0..3.
6. Async reset pulse (not clock-aligned) while out_valid=1 and beat_cnt=1 -> out_valid=0, out_data=0 and in_ready=1 immediately; a fresh two-beat fill completes normally.

Source files
------------

// File: rtl/operand_bank_pingpong_if.sv
// Handshake bundle for the ping-pong operand bank.
//   master : the side that sources beats and consumes banks (drives in_valid,
//            in_data, out_ready, clear).
//   slave  : the operand bank itself (drives in_ready, out_valid, out_data,
//            banks_full).
interface operand_bank_pingpong_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 8,
  parameter int BEAT_LANES = 4
);
  logic                             clear;
  logic                             in_valid;
  logic                             in_ready;
  logic [BEAT_LANES*DATA_WIDTH-1:0] in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [BANK_DEPTH*DATA_WIDTH-1:0] out_data;
  logic [1:0]                       banks_full;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, banks_full
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, banks_full
  );
endinterface

// File: rtl/operand_bank_pingpong.sv
// Double-buffered operand register bank for the systolic array input path.
// Narrow input beats (BEAT_LANES words each) are assembled into a
// BANK_DEPTH-word vector. Two banks alternate: one fills while the other is
// presented to the array until the consumer releases it.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset (clears data and control)
//   bus    : slave side of operand_bank_pingpong_if
//            clear      - synchronous flush of pointers, counter and full flags
//            in_valid / in_ready / in_data    - beat input handshake
//            out_valid / out_ready / out_data - bank presentation handshake
//            banks_full - number of full banks (0..2)
module operand_bank_pingpong #(
  parameter int DATA_WIDTH = 8,
  parameter int BANK_DEPTH = 8,
  parameter int BEAT_LANES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  operand_bank_pingpong_if.slave  bus
);

  localparam int BEATS  = BANK_DEPTH / BEAT_LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BANK_W = BANK_DEPTH * DATA_WIDTH;
  localparam int BEAT_W = BEAT_LANES * DATA_WIDTH;

  logic [BANK_W-1:0] bank0;
  logic [BANK_W-1:0] bank1;
  logic [1:0]        full;
  logic              wr_sel;
  logic              rd_sel;
  logic [CNT_W-1:0]  beat_cnt;

  logic              accept;
  logic              release_bank;
  logic              last_beat;
  logic [1:0]        full_nxt;
  logic [BANK_W-1:0] fill_bank;
  logic [BANK_W-1:0] fill_bank_nxt;

  // Both outputs are plain muxes of registered state; out_ready never
  // reaches in_ready combinationally.
  assign bus.in_ready   = !full[wr_sel];
  assign bus.out_valid  = full[rd_sel];
  assign bus.out_data   = rd_sel ? bank1 : bank0;
  assign bus.banks_full = {1'b0, full[0]} + {1'b0, full[1]};

  assign accept       = bus.in_valid && bus.in_ready && !bus.clear;
  assign release_bank = bus.out_valid && bus.out_ready && !bus.clear;
  assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));
  assign fill_bank    = wr_sel ? bank1 : bank0;

  // Drop the incoming beat into the slot selected by beat_cnt; constant
  // slices per beat position keep the write decode simple.
  always_comb begin
    fill_bank_nxt = fill_bank;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt == CNT_W'(b)) begin
        fill_bank_nxt[b*BEAT_W +: BEAT_W] = bus.in_data;
      end
    end
  end

  // Fill and release can land in the same cycle; they always hit different
  // banks because a full bank is never the one being filled.
  always_comb begin
    full_nxt = full;
    if (accept && last_beat) begin
      full_nxt[wr_sel] = 1'b1;
    end
    if (release_bank) begin
      full_nxt[rd_sel] = 1'b0;
    end
  end

  // Control state: flags, bank pointers and beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 2'b00;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      beat_cnt <= '0;
    end else if (bus.clear) begin
      full     <= 2'b00;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (last_beat) begin
          wr_sel   <= !wr_sel;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
      if (release_bank) begin
        rd_sel <= !rd_sel;
      end
    end
  end

  // Bank data: only written on an accepted beat, retained across clear
  // and release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (accept) begin
      if (wr_sel) begin
        bank1 <= fill_bank_nxt;
      end else begin
        bank0 <= fill_bank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_operand_bank_pingpong.sv
// Directed bench for operand_bank_pingpong with default parameters
// (8-bit words, 8-word banks, 4-lane beats, two beats per bank).
module tb_operand_bank_pingpong;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  operand_bank_pingpong_if #(.DATA_WIDTH(8), .BANK_DEPTH(8), .BEAT_LANES(4)) bus ();

  operand_bank_pingpong #(.DATA_WIDTH(8), .BANK_DEPTH(8), .BEAT_LANES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // 1: reset state
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready",   64'(bus.in_ready),   64'd1);
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_banks_full", 64'(bus.banks_full), 64'd0);
    check("rst_out_data",   bus.out_data,        64'h0);

    // 2: two-beat fill, consumer idle
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h03020100;
    tick();
    check("c2_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("c2_mid_in_ready",  64'(bus.in_ready),  64'd1);
    bus.in_data  = 32'h07060504;
    tick();
    bus.in_valid = 1'b0;
    check("c2_out_valid",  64'(bus.out_valid),  64'd1);
    check("c2_out_data",   bus.out_data,        64'h0706050403020100);
    check("c2_banks_full", 64'(bus.banks_full), 64'd1);
    check("c2_in_ready",   64'(bus.in_ready),   64'd1);

    // 3: flush, then fill both banks and stall a fifth beat
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("c3_clr_banks_full", 64'(bus.banks_full), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h13121110;
    tick();
    bus.in_data  = 32'h17161514;
    tick();
    bus.in_data  = 32'h1B1A1918;
    tick();
    bus.in_data  = 32'h1F1E1D1C;
    tick();
    check("c3_in_ready",   64'(bus.in_ready),   64'd0);
    check("c3_banks_full", 64'(bus.banks_full), 64'd2);
    bus.in_data  = 32'hDEADBEEF;
    tick();
    tick();
    check("c3_stall_in_ready",   64'(bus.in_ready),   64'd0);
    check("c3_stall_banks_full", 64'(bus.banks_full), 64'd2);
    check("c3_stall_out_data",   bus.out_data,        64'h1716151413121110);

    // 4: single release, held beat then lands in bank0 words 0..3
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("c4_out_data",   bus.out_data,        64'h1F1E1D1C1B1A1918);
    check("c4_out_valid",  64'(bus.out_valid),  64'd1);
    check("c4_banks_full", 64'(bus.banks_full), 64'd1);
    check("c4_in_ready",   64'(bus.in_ready),   64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("c4_acc_banks_full", 64'(bus.banks_full), 64'd1);
    check("c4_acc_out_data",   bus.out_data,        64'h1F1E1D1C1B1A1918);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("c4_part_out_valid", 64'(bus.out_valid), 64'd0);
    check("c4_part_out_data",  bus.out_data,       64'h17161514DEADBEEF);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h27262524;
    tick();
    bus.in_valid = 1'b0;
    check("c4_fill_out_valid", 64'(bus.out_valid), 64'd1);
    check("c4_fill_out_data",  bus.out_data,       64'h27262524DEADBEEF);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("c4_drain_banks_full", 64'(bus.banks_full), 64'd0);

    // 5: partial beat discarded by clear; clear beats a same-cycle beat
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hAAAAAAAA;
    tick();
    bus.clear   = 1'b1;
    bus.in_data = 32'h55555555;
    tick();
    bus.clear = 1'b0;
    check("c5_clr_out_valid", 64'(bus.out_valid), 64'd0);
    check("c5_clr_in_ready",  64'(bus.in_ready),  64'd1);
    bus.in_data = 32'h11111111;
    tick();
    bus.in_data = 32'h22222222;
    tick();
    bus.in_valid = 1'b0;
    check("c5_out_valid",  64'(bus.out_valid),  64'd1);
    check("c5_out_data",   bus.out_data,        64'h2222222211111111);
    check("c5_banks_full", 64'(bus.banks_full), 64'd1);

    // Fill of bank1 completing in the same cycle as release of bank0
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h33333333;
    tick();
    bus.in_data   = 32'h44444444;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("sim_out_data",   bus.out_data,        64'h4444444433333333);
    check("sim_out_valid",  64'(bus.out_valid),  64'd1);
    check("sim_banks_full", 64'(bus.banks_full), 64'd1);
    check("sim_in_ready",   64'(bus.in_ready),   64'd1);

    // 6: async reset mid-fill while a bank is presented
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h66666666;
    tick();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("c6_out_valid",  64'(bus.out_valid),  64'd0);
    check("c6_out_data",   bus.out_data,        64'h0);
    check("c6_in_ready",   64'(bus.in_ready),   64'd1);
    check("c6_banks_full", 64'(bus.banks_full), 64'd0);
    #3;
    reset = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77777777;
    tick();
    check("c6_mid_out_valid", 64'(bus.out_valid), 64'd0);
    bus.in_data  = 32'h88888888;
    tick();
    bus.in_valid = 1'b0;
    check("c6_fill_out_valid", 64'(bus.out_valid), 64'd1);
    check("c6_fill_out_data",  bus.out_data,       64'h8888888877777777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
